// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the ALU requesters and alu_share_arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req/op/a/b until gnt, with no other flow control.
//
// Fields, for requester i:
//   req[i]            request level
//   op[2i+1:2i]       opcode (00 ADD, 01 SUB, 10 AND, 11 XOR)
//   a[W*i +: W]       operand A
//   b[W*i +: W]       operand B
// Returned to requesters:
//   gnt/done          one-hot, one-cycle pulses
//   result/carry      outcome of the most recent operation
//   busy              arbiter is in GRANT or EXEC
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [W*NREQ-1:0] a;
    logic [W*NREQ-1:0] b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      result;
    logic              carry;
    logic              busy;

    modport master (
        output req, op, a, b,
        input  gnt, done, result, carry, busy
    );

    modport slave (
        input  req, op, a, b,
        output gnt, done, result, carry, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one W-bit ALU among NREQ requesters: arbitrate, latch operands, execute, return the result.
// Latency: gnt is high the cycle after req is sampled in IDLE; done/result follow two cycles after gnt; one op per 3 cycles.
// Backpressure: no queue. Losers keep req high and are re-evaluated at the next IDLE; a dropped req is never served.
//
// Ports:
//   CLK      clock, all state updates on the rising edge
//   RESET_B  asynchronous active-low reset. Discards any in-flight operation.
//   bus      alu_share_arbiter_if.slave: req/op/a/b in, gnt/done/result/carry/busy out
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration.
// When it is undefined, the lowest-index requester always wins.
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic               CLK,
    input  logic               RESET_B,
    alu_share_arbiter_if.slave bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] win_q,    win_d;
    logic [1:0]       op_q,     op_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q,  carry_d;
    logic [NREQ-1:0]  gnt_q,    gnt_d;
    logic [NREQ-1:0]  done_q,   done_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q,    ptr_d;
    logic [IDX_W-1:0] cand_idx;
`endif

    logic             any_req;
    logic [IDX_W-1:0] pick_idx;

    // ------------------------------------------------------------------
    // Winner selection from the live req vector. The result is only used in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        any_req  = |bus.req;
        pick_idx = '0;
`ifdef ARB_ROUND_ROBIN_EN
        cand_idx = '0;
        // Walk from the farthest candidate (ptr itself) down to ptr+1.
        // The last hit is the requester nearest after ptr, so it wins.
        for (int k = NREQ; k >= 1; k--) begin
            cand_idx = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (bus.req[cand_idx]) begin
                pick_idx = cand_idx;
            end
        end
`else
        // Walk downward so the lowest set index is written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // ALU on the latched operands
    // ------------------------------------------------------------------
    logic [W:0]   alu_sum;
    logic [W-1:0] alu_res;
    logic         alu_c;

    always_comb begin
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            2'b00: begin
                alu_sum = {1'b0, a_q} + {1'b0, b_q};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
            end
            2'b01: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q >= b_q);   // carry means no borrow
            end
            2'b10: begin
                alu_res = a_q & b_q;
            end
            default: begin
                alu_res = a_q ^ b_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        gnt_d    = '0;
        done_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    // Operands are captured here. Later changes by the requester are ignored.
                    state_d = ST_GRANT;
                    win_d   = pick_idx;
                    op_d    = bus.op[2*pick_idx +: 2];
                    a_d     = bus.a[W*pick_idx +: W];
                    b_d     = bus.b[W*pick_idx +: W];
                    gnt_d   = NREQ'(1) << pick_idx;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = pick_idx;
`endif
                end
            end
            ST_GRANT: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // done_q is high during the following IDLE cycle, while result_q holds the new value.
                state_d  = ST_IDLE;
                result_d = alu_res;
                carry_d  = alu_c;
                done_d   = NREQ'(1) << win_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            // Starting at NREQ-1 gives requester 0 first priority after reset.
            ptr_q    <= IDX_W'(NREQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule
